// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF neuron sequencer: one shared 8-bit leak/integrate/fire
// unit walks N_NEURONS membrane potentials per timestep, fetching currents over valid/ready.
module lif_scheduler #(
   parameter int unsigned N_NEURONS = 4,
   parameter int unsigned IDX_W     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 clear,
   input  logic [7:0]           thr,
   input  logic [2:0]           beta_shift,
   input  logic                 reset_zero,
   input  logic [7:0]           cur_data,
   input  logic                 cur_valid,
   output logic                 cur_ready,
   output logic [IDX_W-1:0]     cur_idx,
   output logic                 spike_valid,
   output logic [IDX_W-1:0]     spike_idx,
   output logic                 spike,
   output logic                 done,
   output logic [N_NEURONS-1:0] spikes,
   output logic                 busy,
   input  logic [IDX_W-1:0]     mem_sel,
   output logic [7:0]           mem_out
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   state_t                 state;
   logic [IDX_W-1:0]       idx;
   logic [7:0]             u [N_NEURONS];
   logic [7:0]             thr_q;
   logic [2:0]             bs_q;
   logic                   rz_q;
   logic [7:0]             cur_lat;
   logic [N_NEURONS-1:0]   work;

   logic [7:0]             ucur;
   logic [7:0]             leak;
   logic [8:0]             sum9;
   logic [7:0]             sat;
   logic                   fire;
   logic [7:0]             unew;
   logic [N_NEURONS-1:0]   work_nx;

   // Shared LIF datapath, evaluated for the neuron currently selected by idx
   always_comb begin
      ucur    = u[idx];
      leak    = ucur >> bs_q;
      sum9    = {1'b0, ucur - leak} + {1'b0, cur_lat};
      sat     = sum9[8] ? 8'hff : sum9[7:0];
      fire    = (sat > thr_q);
      unew    = fire ? (rz_q ? '0 : sat - thr_q) : sat;
      work_nx = work;
      work_nx[idx] = fire;
   end

   assign cur_idx = idx;
   assign mem_out = ({1'b0, mem_sel} < (IDX_W+1)'(N_NEURONS)) ? u[mem_sel] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         thr_q       <= '0;
         bs_q        <= '0;
         rz_q        <= 1'b0;
         cur_lat     <= '0;
         work        <= '0;
         cur_ready   <= 1'b0;
         spike_valid <= 1'b0;
         spike_idx   <= '0;
         spike       <= 1'b0;
         done        <= 1'b0;
         spikes      <= '0;
         busy        <= 1'b0;
         for (int unsigned i = 0; i < N_NEURONS; i++) u[i] <= '0;
      end else begin
         spike_valid <= 1'b0;
         done        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (clear) begin
                  for (int unsigned i = 0; i < N_NEURONS; i++) u[i] <= '0;
               end else if (start) begin
                  thr_q     <= thr;
                  bs_q      <= beta_shift;
                  rz_q      <= reset_zero;
                  idx       <= '0;
                  work      <= '0;
                  cur_ready <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (cur_valid) begin
                  cur_lat   <= cur_data;
                  cur_ready <= 1'b0;
                  state     <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               u[idx]      <= unew;
               spike_valid <= 1'b1;
               spike_idx   <= idx;
               spike       <= fire;
               work        <= work_nx;
               if (idx == LAST_IDX) begin
                  // done and spikes are raised on entry so both are visible during DONE
                  done   <= 1'b1;
                  spikes <= work_nx;
                  state  <= S_DONE;
               end else begin
                  idx       <= idx + 1'b1;
                  cur_ready <= 1'b1;
                  state     <= S_FETCH;
               end
            end
            S_DONE: begin
               idx   <= '0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler with hand-computed membrane and timing values.
module tb_lif_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, clear, reset_zero, cur_valid;
   logic [7:0] thr, cur_data, mem_out;
   logic [2:0] beta_shift;
   logic       cur_ready, spike_valid, spike, done, busy;
   logic [1:0] cur_idx, spike_idx, mem_sel;
   logic [3:0] spikes;

   logic [7:0] cur_tab [4];
   int         nchk = 0;
   int         nerr = 0;
   int         sv_n;
   int         sv_cyc [4];
   int         sv_id  [4];
   int         sv_spk [4];
   int         dcyc;
   int         done_seen;

   always #5 clk = ~clk;

   assign cur_data = cur_tab[cur_idx];

   lif_scheduler #(.N_NEURONS(4), .IDX_W(2)) dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .thr(thr),
      .beta_shift(beta_shift), .reset_zero(reset_zero), .cur_data(cur_data),
      .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_idx(cur_idx),
      .spike_valid(spike_valid), .spike_idx(spike_idx), .spike(spike),
      .done(done), .spikes(spikes), .busy(busy), .mem_sel(mem_sel), .mem_out(mem_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic mem_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
      mem_sel = sel;
      #1;
      chk(tag, {24'd0, mem_out}, {24'd0, exp});
   endtask

   // Runs one timestep from a point 1 time unit after a rising edge; returns the cycle of done.
   task automatic do_step(input logic [7:0] t, input logic [2:0] bs, input logic rz,
                          input bit stall, input bit poke, output int dc);
      thr = t; beta_shift = bs; reset_zero = rz; cur_valid = 1'b1; start = 1'b1;
      sv_n = 0;
      dc = -1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc < 60; cyc++) begin
         if (spike_valid && sv_n < 4) begin
            sv_cyc[sv_n] = cyc; sv_id[sv_n] = spike_idx; sv_spk[sv_n] = spike; sv_n++;
         end
         if (done) begin
            dc = cyc;
            break;
         end
         if (stall && cyc >= 3 && cyc <= 5) begin
            cur_valid = 1'b0;
            chk("stall_ready", {31'd0, cur_ready}, 32'd1);
            chk("stall_idx", {30'd0, cur_idx}, 32'd1);
         end else begin
            cur_valid = 1'b1;
         end
         start = poke && (cyc == 4);
         clear = poke && (cyc == 4);
         @(posedge clk); #1;
      end
      start = 1'b0; clear = 1'b0;
      if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      chk("busy_fall", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; clear = 1'b0; thr = '0; beta_shift = '0;
      reset_zero = 1'b0; cur_valid = 1'b0; mem_sel = '0;
      for (int i = 0; i < 4; i++) cur_tab[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_outs", {cur_ready, spike_valid, spike, done, busy, cur_idx, spike_idx, spikes}, '0);
      mem_chk("rst_u0", 2'd0, 8'd0);

      // Leak + subtract reset; first step also checks nominal timing
      cur_tab[0] = 8'd80;
      do_step(8'd100, 3'd1, 1'b0, 1'b0, 1'b0, dcyc);
      chk("nom_done_cyc", dcyc, 32'd9);
      chk("nom_sv_count", sv_n, 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("nom_sv_cyc", sv_cyc[i], 3 + 2 * i);
         chk("nom_sv_idx", sv_id[i], i);
      end
      chk("s1_spikes", {28'd0, spikes}, 32'd0);
      mem_chk("s1_u0", 2'd0, 8'd80);
      do_step(8'd100, 3'd1, 1'b0, 1'b0, 1'b0, dcyc);
      chk("s2_spikes", {28'd0, spikes}, 32'd1);
      chk("s2_spike0", sv_spk[0], 32'd1);
      mem_chk("s2_u0", 2'd0, 8'd20);
      do_step(8'd100, 3'd1, 1'b0, 1'b0, 1'b0, dcyc);
      chk("s3_spikes", {28'd0, spikes}, 32'd0);
      mem_chk("s3_u0", 2'd0, 8'd90);
      mem_chk("s3_u1", 2'd1, 8'd0);

      // start/clear while busy are ignored: 90 - 45 + 0 = 45
      cur_tab[0] = 8'd0;
      do_step(8'd100, 3'd1, 1'b0, 1'b0, 1'b1, dcyc);
      chk("ign_done_cyc", dcyc, 32'd9);
      mem_chk("ign_u0", 2'd0, 8'd45);
      @(posedge clk); #1;
      chk("ign_noqueue", {31'd0, busy}, 32'd0);

      // clear and start together in IDLE
      clear = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; start = 1'b0;
      chk("clr_busy", {31'd0, busy}, 32'd0);
      mem_chk("clr_u0", 2'd0, 8'd0);

      // Zero reset and saturation
      cur_tab[0] = 8'd255;
      do_step(8'd254, 3'd0, 1'b1, 1'b0, 1'b0, dcyc);
      chk("z_spikes", {28'd0, spikes}, 32'd1);
      mem_chk("z_u0", 2'd0, 8'd0);
      cur_tab[0] = 8'd200;
      do_step(8'd255, 3'd3, 1'b1, 1'b0, 1'b0, dcyc);
      mem_chk("sat1_u0", 2'd0, 8'd200);
      do_step(8'd255, 3'd3, 1'b1, 1'b0, 1'b0, dcyc);
      chk("sat2_spikes", {28'd0, spikes}, 32'd0);
      mem_chk("sat2_u0", 2'd0, 8'd255);

      // Handshake stall on neuron 1; other U stay 0
      do_step(8'd255, 3'd3, 1'b1, 1'b1, 1'b0, dcyc);
      chk("stall_done_cyc", dcyc, 32'd12);

      // Reset during UPDATE of neuron 2 (cycle 6)
      cur_tab[1] = 8'd7;
      thr = 8'd255; beta_shift = 3'd0; reset_zero = 1'b0; cur_valid = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      chk("pre_rst_idx", {30'd0, cur_idx}, 32'd2);
      chk("pre_rst_ready", {31'd0, cur_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", {cur_ready, spike_valid, spike, done, busy, cur_idx, spike_idx, spikes}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) mem_chk("mid_rst_u", 2'(i), 8'd0);
      done_seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done || busy) done_seen = 1;
      end
      chk("mid_rst_nodone", done_seen, 32'd0);

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
